// File: rtl/store_byte_writer_if.sv
// Store request / byte-write bus between the load-store buffer, store_byte_writer and the memory write port.
// slave is the writer's view; master is the upstream/memory-side view.
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef SB
`define SB 6'd12
`endif
`ifndef SH
`define SH 6'd13
`endif
`ifndef SW
`define SW 6'd14
`endif

interface store_byte_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                        req_valid;
  logic [`INST_TYPE_WIDTH-1:0] req_ordertype;
  logic [ADDR_W-1:0]           req_addr;
  logic [DATA_W-1:0]           req_data;
  logic                        req_ready;
  logic                        mem_wr;
  logic [ADDR_W-1:0]           mem_a;
  logic [7:0]                  mem_dout;

  modport slave (
    input  req_valid, req_ordertype, req_addr, req_data,
    output req_ready, mem_wr, mem_a, mem_dout
  );

  modport master (
    output req_valid, req_ordertype, req_addr, req_data,
    input  req_ready, mem_wr, mem_a, mem_dout
  );
endinterface

// File: rtl/store_byte_writer.sv
// Serialises one SB/SH/SW store into little-endian byte writes; N-byte store: bytes N cycles after accept, done one cycle later.
// rdy_in low freezes state, idx and latched request and suppresses mem_wr; requests wait on req_ready while busy.
module store_byte_writer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  store_byte_writer_if.slave      bus,
  output logic                    done_out,
  output logic                    busy_out
);

  typedef enum logic {IDLE, WRITE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [2:0]        cnt;
  } req_t;

  state_t            state, state_nxt;
  req_t              lat, lat_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [2:0]        req_cnt;
  logic              accept;
  logic              mem_wr_q, mem_wr_nxt;
  logic [ADDR_W-1:0] mem_a_q, mem_a_nxt;
  logic [7:0]        mem_dout_q, mem_dout_nxt;
  logic              done_nxt, busy_nxt;

  assign bus.req_ready = (state == IDLE) && !rst_in && rdy_in;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_a     = mem_a_q;
  assign bus.mem_dout  = mem_dout_q;

  // Unknown store types still complete, just with nothing to write.
  always_comb begin
    req_cnt = 3'd0;
    case (bus.req_ordertype)
      `SB:     req_cnt = 3'd1;
      `SH:     req_cnt = 3'd2;
      `SW:     req_cnt = 3'd4;
      default: req_cnt = 3'd0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    lat_nxt      = lat;
    idx_nxt      = idx;
    mem_wr_nxt   = 1'b0;
    mem_a_nxt    = mem_a_q;
    mem_dout_nxt = mem_dout_q;
    done_nxt     = 1'b0;
    if (rdy_in) begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_nxt.addr = bus.req_addr;
            lat_nxt.data = bus.req_data;
            lat_nxt.cnt  = req_cnt;
            idx_nxt      = 3'd0;
            state_nxt    = WRITE;
          end
        end
        WRITE: begin
          // One byte per enabled edge; the edge after the last byte closes out with done.
          if (idx != lat.cnt) begin
            mem_wr_nxt   = 1'b1;
            mem_a_nxt    = lat.addr + ADDR_W'(idx);
            mem_dout_nxt = lat.data[{idx[1:0], 3'b000} +: 8];
            idx_nxt      = idx + 3'd1;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt == WRITE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state      <= IDLE;
      lat        <= '0;
      idx        <= 3'd0;
      mem_wr_q   <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'h00;
      done_out   <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      state      <= state_nxt;
      lat        <= lat_nxt;
      idx        <= idx_nxt;
      mem_wr_q   <= mem_wr_nxt;
      mem_a_q    <= mem_a_nxt;
      mem_dout_q <= mem_dout_nxt;
      done_out   <= done_nxt;
      busy_out   <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_store_byte_writer.sv
// Scoreboard bench for store_byte_writer: stimulus queues expected byte writes and done pulses with their cycle numbers.
module tb_store_byte_writer;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic done_out;
  logic busy_out;

  store_byte_writer_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  store_byte_writer #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .bus      (bus),
    .done_out (done_out),
    .busy_out (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int          cyc;
    logic [31:0] a;
    logic [7:0]  d;
  } ev_t;

  ev_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_wr(input int c, input logic [31:0] a, input logic [7:0] d);
    ev_t e;
    e.is_done = 1'b0;
    e.cyc     = c;
    e.a       = a;
    e.d       = d;
    sbq.push_back(e);
  endtask

  task automatic push_done(input int c);
    ev_t e;
    e.is_done = 1'b1;
    e.cyc     = c;
    e.a       = 32'h0;
    e.d       = 8'h00;
    sbq.push_back(e);
  endtask

  // Monitor: every write strobe or done pulse must match the head of the scoreboard.
  always @(negedge clk_in) begin
    ev_t e;
    bit  bad;
    if (bus.mem_wr === 1'b1 || done_out === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc %0d mem_wr=%b done=%b a=%h d=%h, required no event",
                 cyc, bus.mem_wr, done_out, bus.mem_a, bus.mem_dout);
      end else begin
        e = sbq.pop_front();
        if (e.is_done)
          bad = !(done_out === 1'b1 && bus.mem_wr === 1'b0 && cyc == e.cyc && bus.req_ready === 1'b1);
        else
          bad = !(bus.mem_wr === 1'b1 && done_out === 1'b0 && cyc == e.cyc &&
                  bus.mem_a === e.a && bus.mem_dout === e.d && busy_out === 1'b1);
        if (bad) begin
          errors++;
          $display("FAIL %s: got cyc %0d wr=%b done=%b a=%h d=%h busy=%b rdy=%b, required cyc %0d a=%h d=%h",
                   e.is_done ? "done_event" : "write_event", cyc, bus.mem_wr, done_out,
                   bus.mem_a, bus.mem_dout, busy_out, bus.req_ready, e.cyc, e.a, e.d);
        end
      end
    end
  end

  // exp_bytes holds the expected bytes in write order, first byte in the top 8 bits.
  task automatic issue(input logic [5:0] t, input logic [31:0] a, input logic [31:0] d,
                       input int n, input logic [31:0] exp_bytes, input bit hold,
                       input bit push, output int e0);
    int k;
    @(negedge clk_in);
    bus.req_valid     = 1'b1;
    bus.req_ordertype = t;
    bus.req_addr      = a;
    bus.req_data      = d;
    k = 0;
    while (bus.req_ready !== 1'b1 && k < 100) begin
      @(negedge clk_in);
      k++;
    end
    if (bus.req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%b after %0d cycles, required 1", bus.req_ready, k);
      bus.req_valid = 1'b0;
      e0 = -1;
    end else begin
      @(posedge clk_in);
      #1;
      e0 = cyc;
      if (!hold) bus.req_valid = 1'b0;
      if (push) begin
        for (int i = 0; i < n; i++)
          push_wr(e0 + 1 + i, a + 32'(i), exp_bytes[31 - 8*i -: 8]);
        push_done(e0 + n + 1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    rst_in            = 1'b1;
    rdy_in            = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_ordertype = '0;
    bus.req_addr      = '0;
    bus.req_data      = '0;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;

    @(negedge clk_in);
    chk("rst_mem_wr",    32'(bus.mem_wr),    32'd0);
    chk("rst_mem_a",     bus.mem_a,          32'h0);
    chk("rst_mem_dout",  32'(bus.mem_dout),  32'h0);
    chk("rst_done",      32'(done_out),      32'd0);
    chk("rst_busy",      32'(busy_out),      32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // SW 0x100 / 0xDEADBEEF
    issue(`SW, 32'h100, 32'hDEADBEEF, 4, 32'hEFBEADDE, 1'b0, 1'b1, e0);
    @(negedge clk_in);
    chk("sw_busy_after_accept",   32'(busy_out),   32'd1);
    chk("sw_no_wr_after_accept",  32'(bus.mem_wr), 32'd0);
    repeat (6) step();

    // SB 0x2003 / 0x123456A5
    issue(`SB, 32'h2003, 32'h123456A5, 1, 32'hA5000000, 1'b0, 1'b1, e0);
    repeat (4) step();

    // SH across the top of the address space
    issue(`SH, 32'hFFFFFFFF, 32'h0000CAFE, 2, 32'hFECA0000, 1'b0, 1'b1, e0);
    repeat (5) step();

    // SW with two disabled cycles after the first byte
    issue(`SW, 32'h400, 32'h11223344, 4, 32'h0, 1'b0, 1'b0, e0);
    push_wr(e0 + 1, 32'h400, 8'h44);
    push_wr(e0 + 4, 32'h401, 8'h33);
    push_wr(e0 + 5, 32'h402, 8'h22);
    push_wr(e0 + 6, 32'h403, 8'h11);
    push_done(e0 + 7);
    step();
    rdy_in = 1'b0;
    step();
    @(negedge clk_in);
    chk("stall_mem_wr",   32'(bus.mem_wr),   32'd0);
    chk("stall_mem_a",    bus.mem_a,         32'h400);
    chk("stall_mem_dout", 32'(bus.mem_dout), 32'h44);
    chk("stall_busy",     32'(busy_out),     32'd1);
    step();
    rdy_in = 1'b1;
    repeat (8) step();

    // Reset in the middle of a SW, then an immediate SB
    issue(`SW, 32'h300, 32'hA1B2C3D4, 4, 32'h0, 1'b0, 1'b0, e0);
    push_wr(e0 + 1, 32'h300, 8'hD4);
    push_wr(e0 + 2, 32'h301, 8'hC3);
    step();
    step();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst_in = 1'b0;
    #1;
    chk("rst_mid_mem_wr",    32'(bus.mem_wr),    32'd0);
    chk("rst_mid_busy",      32'(busy_out),      32'd0);
    chk("rst_mid_done",      32'(done_out),      32'd0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    issue(`SB, 32'h55, 32'hFFFFFF77, 1, 32'h77000000, 1'b0, 1'b1, e1);
    chk("rst_reaccept_edge", 32'(e1), 32'(e0 + 4));
    repeat (5) step();

    // Unsupported type: no write, done one enabled cycle later
    issue(6'd0, 32'h700, 32'h12345678, 0, 32'h0, 1'b0, 1'b1, e0);
    repeat (4) step();

    // Back-to-back with req_valid held high
    issue(`SB, 32'h10, 32'h00000011, 1, 32'h11000000, 1'b1, 1'b1, e0);
    issue(`SH, 32'h20, 32'h0000BBAA, 2, 32'hAABB0000, 1'b0, 1'b1, e1);
    chk("b2b_accept_edge", 32'(e1), 32'(e0 + 3));
    repeat (6) step();

    for (int k = 0; k < 50 && sbq.size() != 0; k++) step();
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
